router_ingress: RTL and testbench
=================================

ROUTER_INGRESS -- requirements
Module: router_ingress

Interface
REQ-001 SHALL expose: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL expose: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL expose: pkt_valid  input  1  data_in carries a valid byte this cycle.
REQ-004 SHALL expose: data_in  input  8  packet byte stream (header, payload, parity).
REQ-005 SHALL expose: fifo_full  input  3  full flag of destination FIFO 0..2.
REQ-006 SHALL expose: fifo_empty  input  3  empty flag of destination FIFO 0..2.
REQ-007 SHALL expose: busy  output  1  byte on data_in is not accepted this cycle.
REQ-008 SHALL expose: data_out  output  8  byte presented to destination FIFOs.
REQ-009 SHALL expose: write_enb  output  3  one-hot write strobe, bit = destination.
REQ-010 SHALL expose: lfd_state  output  1  header-write-next marker for destination FIFO.
REQ-011 SHALL expose: parity_done  output  1  one-cycle pulse, parity byte accepted.
REQ-012 SHALL expose: err  output  1  parity mismatch on last packet.
REQ-013 SHALL expose parameter MAX_DEST, default 3, number of destinations.

Function
REQ-014 Packet format SHALL be: header {len[7:2], addr[1:0]}, then len payload bytes (0..63), then one parity byte.
REQ-015 A byte SHALL be accepted on a rising edge where pkt_valid=1 and busy=0 in states DECODE, LOAD_DATA, LOAD_PARITY, DROP.
REQ-016 States SHALL be DECODE, WAIT_EMPTY, LFD, LOAD_DATA, LOAD_PARITY, CHECK_PARITY, DROP.
REQ-017 DECODE: on accepted byte with addr<3 latch header, clear parity accumulator and err, go LFD if fifo_empty[addr] else WAIT_EMPTY; addr=3 -> DROP.
REQ-018 DROP: accept and discard bytes; return to DECODE on first cycle with pkt_valid=0.
REQ-019 WAIT_EMPTY: busy=1; go LFD when fifo_empty[addr]=1.
REQ-020 LFD: busy=1, lfd_state=1 for exactly this one cycle; exit loads header into hold register, go LOAD_DATA (len>0) or LOAD_PARITY (len=0).
REQ-021 Hold register SHALL be one byte plus hold_valid; write_enb[addr]=hold_valid & ~fifo_full[addr], data_out=hold byte, other write_enb bits 0.
REQ-022 Header write SHALL occur in the cycle immediately after LFD.
REQ-023 busy SHALL equal 1 in WAIT_EMPTY, LFD, CHECK_PARITY, and whenever hold_valid & fifo_full[addr]; hold drain and refill in the same cycle SHALL be allowed.
REQ-024 LOAD_DATA: each accepted byte enters hold, XORs into accumulator, decrements remaining count; after len-th byte go LOAD_PARITY.
REQ-025 LOAD_PARITY: accepted byte enters hold (written to FIFO); parity_done pulses next cycle; err<=(byte != accumulator); go CHECK_PARITY.
REQ-026 CHECK_PARITY: busy=1 until hold_valid=0, then go DECODE.
REQ-027 Accumulator SHALL be XOR of header and all payload bytes; remaining count 6 bits, no wrap below 0.
REQ-028 pkt_valid=0 gaps mid-packet SHALL hold state without effect.
REQ-029 err SHALL stay set until the next valid header is accepted.

Reset
REQ-030 reset=1 SHALL force DECODE, hold_valid=0, data_out=0, write_enb=0, lfd_state=0, busy=0, parity_done=0, err=0, accumulator=0.
REQ-031 Reset mid-packet SHALL abandon the packet; no further FIFO writes for it.

Structure
REQ-032 Shared package router_pkg SHALL hold state enum, ADDR_INVALID=2'b11, LEN/ADDR field positions, MAX_DEST.
REQ-033 Sub-module router_parity (accumulator plus compare) SHALL be instantiated once.

Verification
REQ-034 Header 8'h0D (len 3, addr 1), payload 11,22,33, parity 8'h0D^11^22^33, FIFO1 empty -> lfd_state one cycle, 5 write_enb[1] strobes, parity_done, err=0.
REQ-035 Same packet, parity byte 8'h00 -> parity byte still written, err=1 until next header.
REQ-036 Header addr 2, fifo_empty[2]=0 for 4 cycles -> busy=1 for 4 cycles plus LFD, no writes until empty.
REQ-037 16-byte payload, fifo_full[0] asserted 3 cycles mid-packet -> busy=1 those cycles, no byte lost or duplicated.
REQ-038 Header 8'h07 (addr 3) plus 2 bytes, then pkt_valid=0 -> no write_enb, returns DECODE.
REQ-039 reset asserted after 2nd payload byte -> all outputs 0 next cycle, next packet handled normally.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and types for the router ingress block.
// Header field positions, destination count and FSM encodings.
package router_pkg;

    localparam int MAX_DEST = 3;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    typedef logic [2:0] state_t;

    localparam state_t ST_DECODE     = 3'd0;
    localparam state_t ST_WAIT_EMPTY = 3'd1;
    localparam state_t ST_LFD        = 3'd2;
    localparam state_t ST_LOAD_DATA  = 3'd3;
    localparam state_t ST_LOAD_PAR   = 3'd4;
    localparam state_t ST_CHECK_PAR  = 3'd5;
    localparam state_t ST_DROP       = 3'd6;

endpackage

// File: rtl/router_ingress_if.sv
// Byte-stream ingress bus between packet source and router.
// Carries stream input, FIFO status and FIFO write side.
interface router_ingress_if #(
    parameter int N = 3
);
    logic         pkt_valid;
    logic [7:0]   data_in;
    logic [N-1:0] fifo_full;
    logic [N-1:0] fifo_empty;
    logic         busy;
    logic [7:0]   data_out;
    logic [N-1:0] write_enb;
    logic         lfd_state;
    logic         parity_done;
    logic         err;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty,
        input  busy, data_out, write_enb, lfd_state,
        input  parity_done, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty,
        output busy, data_out, write_enb, lfd_state,
        output parity_done, err
    );
endinterface

// File: rtl/router_parity.sv
// Running XOR over header and payload, checked against
// the trailing parity byte of each packet.
module router_parity (
    input  logic       clk,
    input  logic       reset,
    input  logic       hdr_ld,
    input  logic       dat_ld,
    input  logic       par_ld,
    input  logic [7:0] din,
    output logic       err,
    output logic       parity_done
);
    logic [7:0] acc;

    // accumulate, compare on parity byte, pulse done
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= 8'h00;
            err         <= 1'b0;
            parity_done <= 1'b0;
        end else begin
            parity_done <= par_ld;
            if (hdr_ld) begin
                acc <= din;
                err <= 1'b0;
            end else if (dat_ld) begin
                acc <= acc ^ din;
            end
            if (par_ld) begin
                err <= (din != acc);
            end
        end
    end
endmodule

// File: rtl/router_ingress.sv
// Packet ingress: decodes header, stages bytes through a
// one-byte hold register into the addressed FIFO.
module router_ingress #(
    parameter int MAX_DEST = router_pkg::MAX_DEST
) (
    input  logic            clk,
    input  logic            reset,
    router_ingress_if.slave bus
);
    import router_pkg::*;

    state_t              state;
    logic [7:0]          hdr;
    logic [7:0]          hold;
    logic                hold_valid;
    logic [5:0]          remain;
    logic [1:0]          addr;
    logic [1:0]          in_addr;
    logic [5:0]          len;
    logic [MAX_DEST-1:0] sel;
    logic [MAX_DEST-1:0] in_sel;
    logic                full_sel;
    logic                empty_sel;
    logic                in_empty;
    logic                hdr_ok;
    logic                busy;
    logic                drain;
    logic                can_take;
    logic                accept;
    logic                load_hold;
    logic                hdr_ld;
    logic                dat_ld;
    logic                par_ld;

    assign addr    = hdr[ADDR_MSB:ADDR_LSB];
    assign len     = hdr[LEN_MSB:LEN_LSB];
    assign in_addr = bus.data_in[ADDR_MSB:ADDR_LSB];

    // one-hot decode of latched and incoming destination
    always_comb begin
        sel    = '0;
        in_sel = '0;
        for (int i = 0; i < MAX_DEST; i++) begin
            sel[i]    = (int'(addr) == i);
            in_sel[i] = (int'(in_addr) == i);
        end
    end

    assign full_sel  = |(bus.fifo_full & sel);
    assign empty_sel = |(bus.fifo_empty & sel);
    assign in_empty  = |(bus.fifo_empty & in_sel);
    assign hdr_ok    = (in_addr != ADDR_INVALID) && (|in_sel);

    assign busy = (state inside {ST_WAIT_EMPTY, ST_LFD,
                                 ST_CHECK_PAR})
                | (hold_valid & full_sel);

    assign can_take = state inside {ST_DECODE, ST_LOAD_DATA,
                                    ST_LOAD_PAR, ST_DROP};
    assign accept   = bus.pkt_valid & ~busy & can_take;
    assign drain    = hold_valid & ~full_sel;

    assign hdr_ld = accept & (state == ST_DECODE) & hdr_ok;
    assign dat_ld = accept & (state == ST_LOAD_DATA);
    assign par_ld = accept & (state == ST_LOAD_PAR);

    assign load_hold = (state == ST_LFD) | dat_ld | par_ld;

    assign bus.busy      = busy;
    assign bus.data_out  = hold;
    assign bus.write_enb = sel & {MAX_DEST{drain}};
    assign bus.lfd_state = (state == ST_LFD);

    router_parity u_parity (
        .clk         (clk),
        .reset       (reset),
        .hdr_ld      (hdr_ld),
        .dat_ld      (dat_ld),
        .par_ld      (par_ld),
        .din         (bus.data_in),
        .err         (bus.err),
        .parity_done (bus.parity_done)
    );

    // packet sequencing: header, wait, lfd, data, parity
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_DECODE;
            hdr    <= 8'h00;
            remain <= 6'd0;
        end else begin
            unique case (state)
                ST_DECODE: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            hdr   <= bus.data_in;
                            state <= in_empty ? ST_LFD
                                              : ST_WAIT_EMPTY;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_WAIT_EMPTY: begin
                    if (empty_sel) state <= ST_LFD;
                end
                ST_LFD: begin
                    remain <= len;
                    state  <= (len == 6'd0) ? ST_LOAD_PAR
                                            : ST_LOAD_DATA;
                end
                ST_LOAD_DATA: begin
                    if (accept) begin
                        if (remain != 6'd0)
                            remain <= remain - 6'd1;
                        if (remain <= 6'd1)
                            state <= ST_LOAD_PAR;
                    end
                end
                ST_LOAD_PAR: begin
                    if (accept) state <= ST_CHECK_PAR;
                end
                ST_CHECK_PAR: begin
                    if (!hold_valid) state <= ST_DECODE;
                end
                ST_DROP: begin
                    if (!bus.pkt_valid) state <= ST_DECODE;
                end
                default: state <= ST_DECODE;
            endcase
        end
    end

    // hold register: refill may coincide with a drain
    always_ff @(posedge clk) begin
        if (reset) begin
            hold       <= 8'h00;
            hold_valid <= 1'b0;
        end else if (load_hold) begin
            hold       <= (state == ST_LFD) ? hdr : bus.data_in;
            hold_valid <= 1'b1;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_router_ingress.sv
// Directed bench for router_ingress with a write scoreboard.
// Expected FIFO writes are queued as bytes are offered.
module tb_router_ingress;

    logic clk;
    logic reset;

    router_ingress_if #(.N(3)) bus ();

    router_ingress #(.MAX_DEST(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int lfd_cnt = 0;
    int pd_cnt = 0;
    logic [10:0] exp_q[$];
    logic [2:0] cur_sel;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic mon();
        logic [10:0] e;
        if (!reset) begin
            lfd_cnt += int'(bus.lfd_state);
            pd_cnt  += int'(bus.parity_done);
            if (bus.write_enb != 3'b000) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected",
                        32'(bus.write_enb), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_strobe_data",
                        32'({bus.write_enb, bus.data_out}),
                        32'(e));
                end
            end
        end
    endtask

    task automatic step_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic step_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.pkt_valid = 1'b0;
        repeat (n) begin
            step_neg();
            step_pos();
        end
    endtask

    task automatic send(input logic [7:0] b, input bit push);
        bit ok;
        ok = 1'b0;
        bus.pkt_valid = 1'b1;
        bus.data_in   = b;
        if (push) exp_q.push_back({cur_sel, b});
        for (int k = 0; k < 50 && !ok; k++) begin
            step_neg();
            if (!bus.busy) ok = 1'b1;
            step_pos();
        end
        if (!ok) chk("accept_timeout", 32'(bus.busy), 32'(0));
    endtask

    task automatic send_pkt(input logic [7:0] h,
                            input int n,
                            input logic [7:0] base,
                            input bit bad,
                            input int stall_at);
        logic [7:0] p;
        logic [7:0] b;
        logic [1:0] a;
        a = h[1:0];
        cur_sel = 3'b001 << a;
        p = h;
        send(h, 1'b1);
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i * 17);
            p = p ^ b;
            if (i == stall_at) begin
                bus.pkt_valid = 1'b1;
                bus.data_in   = b;
                bus.fifo_full = cur_sel;
                repeat (3) begin
                    step_neg();
                    chk("stall_busy", 32'(bus.busy), 32'(1));
                    chk("stall_wr", 32'(bus.write_enb), 32'(0));
                    step_pos();
                end
                bus.fifo_full = 3'b000;
            end
            send(b, 1'b1);
        end
        send(bad ? 8'h00 : p, 1'b1);
        bus.pkt_valid = 1'b0;
    endtask

    initial begin
        int w0;
        int l0;
        int p0;
        reset          = 1'b1;
        bus.pkt_valid  = 1'b0;
        bus.data_in    = 8'h00;
        bus.fifo_full  = 3'b000;
        bus.fifo_empty = 3'b111;
        cur_sel        = 3'b000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        step_neg();
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_wr", 32'(bus.write_enb), 32'(0));
        chk("rst_dout", 32'(bus.data_out), 32'(0));
        chk("rst_lfd", 32'(bus.lfd_state), 32'(0));
        chk("rst_pd", 32'(bus.parity_done), 32'(0));
        chk("rst_err", 32'(bus.err), 32'(0));
        step_pos();

        w0 = wr_cnt; l0 = lfd_cnt; p0 = pd_cnt;
        send_pkt(8'h0D, 3, 8'h11, 1'b0, -1);
        idle(4);
        chk("good_writes", 32'(wr_cnt - w0), 32'(5));
        chk("good_lfd", 32'(lfd_cnt - l0), 32'(1));
        chk("good_pd", 32'(pd_cnt - p0), 32'(1));
        chk("good_err", 32'(bus.err), 32'(0));

        w0 = wr_cnt; p0 = pd_cnt;
        send_pkt(8'h0D, 3, 8'h11, 1'b1, -1);
        idle(4);
        chk("bad_writes", 32'(wr_cnt - w0), 32'(5));
        chk("bad_pd", 32'(pd_cnt - p0), 32'(1));
        chk("bad_err", 32'(bus.err), 32'(1));
        idle(3);
        chk("bad_err_held", 32'(bus.err), 32'(1));

        w0 = wr_cnt;
        cur_sel = 3'b100;
        bus.fifo_empty = 3'b011;
        send(8'h06, 1'b1);
        bus.pkt_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step_neg();
            if (j == 0) chk("hdr_clr_err", 32'(bus.err), 32'(0));
            chk("wait_busy", 32'(bus.busy), 32'(1));
            chk("wait_lfd", 32'(bus.lfd_state), 32'(0));
            chk("wait_wr", 32'(bus.write_enb), 32'(0));
            step_pos();
        end
        bus.fifo_empty = 3'b111;
        step_neg();
        chk("wait_last_busy", 32'(bus.busy), 32'(1));
        chk("wait_last_lfd", 32'(bus.lfd_state), 32'(0));
        step_pos();
        step_neg();
        chk("lfd_pulse", 32'(bus.lfd_state), 32'(1));
        chk("lfd_busy", 32'(bus.busy), 32'(1));
        chk("lfd_no_wr", 32'(bus.write_enb), 32'(0));
        step_pos();
        send(8'h5A, 1'b1);
        send(8'h06 ^ 8'h5A, 1'b1);
        idle(4);
        chk("wait_writes", 32'(wr_cnt - w0), 32'(3));
        chk("wait_err", 32'(bus.err), 32'(0));

        w0 = wr_cnt; l0 = lfd_cnt;
        send_pkt(8'h02, 0, 8'h00, 1'b0, -1);
        idle(4);
        chk("len0_writes", 32'(wr_cnt - w0), 32'(2));
        chk("len0_lfd", 32'(lfd_cnt - l0), 32'(1));
        chk("len0_err", 32'(bus.err), 32'(0));

        w0 = wr_cnt;
        send_pkt(8'h40, 16, 8'h01, 1'b0, 6);
        idle(4);
        chk("stall_writes", 32'(wr_cnt - w0), 32'(18));
        chk("stall_err", 32'(bus.err), 32'(0));

        w0 = wr_cnt; l0 = lfd_cnt;
        send(8'h07, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        idle(3);
        chk("drop_writes", 32'(wr_cnt - w0), 32'(0));
        chk("drop_lfd", 32'(lfd_cnt - l0), 32'(0));
        chk("drop_busy", 32'(bus.busy), 32'(0));

        cur_sel = 3'b010;
        send(8'h0D, 1'b1);
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        reset = 1'b1;
        bus.pkt_valid = 1'b0;
        step_neg();
        step_pos();
        reset = 1'b0;
        step_neg();
        chk("mrst_busy", 32'(bus.busy), 32'(0));
        chk("mrst_wr", 32'(bus.write_enb), 32'(0));
        chk("mrst_dout", 32'(bus.data_out), 32'(0));
        chk("mrst_lfd", 32'(bus.lfd_state), 32'(0));
        chk("mrst_pd", 32'(bus.parity_done), 32'(0));
        chk("mrst_err", 32'(bus.err), 32'(0));
        chk("mrst_queue", 32'(exp_q.size()), 32'(0));
        step_pos();
        idle(2);

        w0 = wr_cnt; l0 = lfd_cnt; p0 = pd_cnt;
        send_pkt(8'h0D, 3, 8'h11, 1'b0, -1);
        idle(4);
        chk("post_writes", 32'(wr_cnt - w0), 32'(5));
        chk("post_lfd", 32'(lfd_cnt - l0), 32'(1));
        chk("post_pd", 32'(pd_cnt - p0), 32'(1));
        chk("post_err", 32'(bus.err), 32'(0));
        chk("final_queue", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
